// File: rtl/seq_block_adder.sv
// Multi-cycle adder/subtractor: one BLOCK-bit slice per clock, carry held in a register.
// Optional SEQ_BLOCK_ADDER_ZERO_EN adds a registered all-zero result flag on port zero.
module seq_block_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SEQ_BLOCK_ADDER_ZERO_EN
    output logic             ovf,
    output logic             zero
`else
    output logic             ovf
`endif
);

    localparam int NUM_BLOCKS = WIDTH / BLOCK;
    localparam int CNT_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic [BLOCK-1:0] a_slice;
    logic [BLOCK-1:0] b_slice;
    logic [BLOCK-1:0] s;
    logic             c;
    logic             accept;
    logic             last;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt_q == LAST_IDX);

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

    // One slice of the ripple: BLOCK+1-bit add so the slice carry falls out on top.
    always_comb begin
        a_slice = a_reg[int'(cnt_q)*BLOCK +: BLOCK];
        b_slice = b_reg[int'(cnt_q)*BLOCK +: BLOCK];
        {c, s}  = {1'b0, a_slice} + {1'b0, b_slice} + {{BLOCK{1'b0}}, carry_q};
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = BUSY;
            BUSY:    if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q   <= '0;
                        carry_q <= sub ? 1'b1 : cin;
                    end
                end
                BUSY: begin
                    sum_q[int'(cnt_q)*BLOCK +: BLOCK] <= s;
                    carry_q <= c;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last) begin
                        cout_q <= c;
                        ovf_q  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                  (s[BLOCK-1] != a_reg[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded on accept before use.
    always_ff @(posedge clock) begin
        if (accept) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
        end
    end

`ifdef SEQ_BLOCK_ADDER_ZERO_EN
    logic zero_q;

    assign zero = zero_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            zero_q <= 1'b0;
        end else if (accept) begin
            zero_q <= 1'b1;
        end else if (state_q == BUSY) begin
            zero_q <= zero_q && (s == '0);
        end
    end
`endif

endmodule

// File: tb/tb_seq_block_adder.sv
// Directed self-checking bench for seq_block_adder at BLOCK=8, plus BLOCK=32 and BLOCK=4 instances.
module tb_seq_block_adder;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_valid_x;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        in_ready32, out_valid32, cout32, ovf32;
    logic        in_ready4, out_valid4, cout4, ovf4;
    logic [31:0] sum32;
    logic [31:0] sum4;
`ifdef SEQ_BLOCK_ADDER_ZERO_EN
    logic        zero;
    logic        zero32;
    logic        zero4;
`endif

    int checks = 0;
    int errors = 0;
    int lat;
    int lat32;
    int lat4;

    always #5 clock = ~clock;

    seq_block_adder #(.WIDTH(32), .BLOCK(8)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
`ifdef SEQ_BLOCK_ADDER_ZERO_EN
        .zero(zero),
`endif
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    seq_block_adder #(.WIDTH(32), .BLOCK(32)) u_dut32 (
        .clock(clock), .reset(reset), .in_valid(in_valid_x), .in_ready(in_ready32),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid32), .out_ready(out_ready),
`ifdef SEQ_BLOCK_ADDER_ZERO_EN
        .zero(zero32),
`endif
        .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    seq_block_adder #(.WIDTH(32), .BLOCK(4)) u_dut4 (
        .clock(clock), .reset(reset), .in_valid(in_valid_x), .in_ready(in_ready4),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid4), .out_ready(out_ready),
`ifdef SEQ_BLOCK_ADDER_ZERO_EN
        .zero(zero4),
`endif
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one operation on the BLOCK=8 instance and count edges until out_valid.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_op, input logic tcin,
                          input logic tsub, output int tlat);
        a = ta;
        b = tb_op;
        cin = tcin;
        sub = tsub;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tlat = 0;
        while (!out_valid && tlat < 50) begin
            step();
            tlat++;
        end
    endtask

    task automatic check_result(input string tag, input int tlat, input logic [31:0] exp_sum,
                                input logic exp_cout, input logic exp_ovf, input logic exp_zero);
        check({tag, "_lat"}, 64'(tlat), 64'd4);
        check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
        check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`ifdef SEQ_BLOCK_ADDER_ZERO_EN
        check({tag, "_zero"}, 64'(zero), 64'(exp_zero));
`else
        if (exp_zero) checks += 0;
`endif
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_rel_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_rel_out_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_valid_x = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        step();
        step();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        reset = 1'b0;

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
        check_result("wrap", lat, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        release_out("wrap");

        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
        check_result("add_ovf", lat, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        release_out("add_ovf");

        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, lat);
        check_result("sub_ovf", lat, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        release_out("sub_ovf");

        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, lat);
        check_result("sub_borrow", lat, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        release_out("sub_borrow");

        run_op(32'h1234_5678, 32'h0000_000F, 1'b1, 1'b0, lat);
        check_result("add_cin", lat, 32'h1234_5688, 1'b0, 1'b0, 1'b0);
        release_out("add_cin");

        // Back-pressure: result held while a new op is offered and refused.
        run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, lat);
        check_result("bp_first", lat, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0002;
        cin = 1'b0;
        sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_sum", 64'(sum), 64'h7);
            check("bp_cout", 64'(cout), 64'd0);
            check("bp_ovf", 64'(ovf), 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_idle_in_ready", 64'(in_ready), 64'd1);
        check("bp_idle_out_valid", 64'(out_valid), 64'd0);
        check("bp_idle_sum_kept", 64'(sum), 64'h7);
        step();
        in_valid = 1'b0;
        check("bp_accept_busy", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        check_result("bp_second", lat, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        release_out("bp_second");

        // Reset during the second BUSY cycle, after slice 0 has been written.
        a = 32'h1111_1111;
        b = 32'h2222_2222;
        sub = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_sum", 64'(sum), 64'd0);
        check("mid_rst_cout", 64'(cout), 64'd0);
        check("mid_rst_ovf", 64'(ovf), 64'd0);
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, lat);
        check_result("post_rst", lat, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        release_out("post_rst");

        // Same wrap-around op on the BLOCK=32 and BLOCK=4 instances.
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0001;
        cin = 1'b0;
        sub = 1'b0;
        in_valid_x = 1'b1;
        step();
        in_valid_x = 1'b0;
        lat32 = -1;
        lat4 = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (lat32 < 0 && out_valid32) lat32 = i;
            if (lat4 < 0 && out_valid4) lat4 = i;
        end
        check("b32_lat", 64'(lat32), 64'd1);
        check("b32_sum", 64'(sum32), 64'd0);
        check("b32_cout", 64'(cout32), 64'd1);
        check("b32_ovf", 64'(ovf32), 64'd0);
        check("b4_lat", 64'(lat4), 64'd8);
        check("b4_sum", 64'(sum4), 64'd0);
        check("b4_cout", 64'(cout4), 64'd1);
        check("b4_ovf", 64'(ovf4), 64'd0);
`ifdef SEQ_BLOCK_ADDER_ZERO_EN
        check("b32_zero", 64'(zero32), 64'd1);
        check("b4_zero", 64'(zero4), 64'd1);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("b32_rel_in_ready", 64'(in_ready32), 64'd1);
        check("b4_rel_in_ready", 64'(in_ready4), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
